// File: rtl/if3_predecode_redirect_if.sv
// IF3 predecode bus: fetch group and NLP prediction in, redirect/kill and NLP training out.
interface if3_predecode_redirect_if;
  logic        flush;
  logic        pause;
  logic        grp_valid;
  logic [31:0] grp_pc;
  logic [31:0] inst0;
  logic [31:0] inst1;
  logic        nlp_taken0;
  logic        nlp_taken1;
  logic [31:0] nlp_target0;
  logic [31:0] nlp_target1;
  logic        redirect;
  logic [31:0] redirectPC;
  logic        kill1;
  logic        wait_ds;
  logic        nlp_upd_valid;
  logic [31:0] nlp_upd_pc;
  logic [31:0] nlp_upd_target;
  logic        nlp_upd_taken;

  modport master (
    output flush, pause, grp_valid, grp_pc, inst0, inst1,
    output nlp_taken0, nlp_taken1, nlp_target0, nlp_target1,
    input  redirect, redirectPC, kill1, wait_ds,
    input  nlp_upd_valid, nlp_upd_pc, nlp_upd_target, nlp_upd_taken
  );

  modport slave (
    input  flush, pause, grp_valid, grp_pc, inst0, inst1,
    input  nlp_taken0, nlp_taken1, nlp_target0, nlp_target1,
    output redirect, redirectPC, kill1, wait_ds,
    output nlp_upd_valid, nlp_upd_pc, nlp_upd_target, nlp_upd_taken
  );
endinterface

// File: rtl/if3_predecode_redirect.sv
// IF3 predecoder: checks a two-slot fetch group against NLP predictions, redirects IF0
// (respecting the MIPS delay slot) and emits a one-cycle NLP training pulse.
module if3_predecode_redirect #(
  parameter bit FIX_COND_TARGET = 1'b1,
  parameter bit FIX_J_MISS      = 1'b1
) (
  input logic                     clk,
  input logic                     rst,
  if3_predecode_redirect_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StWaitDs} state_e;

  typedef struct packed {
    logic        ctrl;
    logic        fp;
    logic        err;
    logic [31:0] tgt;
  } slot_t;

  function automatic slot_t eval_slot(input logic [31:0] inst, input logic [31:0] pc,
                                      input logic [31:0] fall, input logic [31:0] nlp_tgt,
                                      input logic nlp_tk);
    slot_t       s;
    logic [5:0]  op;
    logic [31:0] pc4, t;
    logic        is_j, is_cond, is_ind, fix_j, fix_c;
    op      = inst[31:26];
    pc4     = pc + 32'd4;
    is_j    = (op == 6'h02) || (op == 6'h03);
    // REGIMM only counts as a branch for rt = 0..3
    is_cond = (op[5:2] == 4'h1) || ((op == 6'h01) && (inst[20:18] == 3'b000));
    is_ind  = (op == 6'h00) && (inst[5:1] == 5'b00100);
    t       = is_j ? {pc4[31:28], inst[25:0], 2'b00}
                   : pc4 + {{14{inst[15]}}, inst[15:0], 2'b00};
    fix_j   = is_j && ((!nlp_tk && FIX_J_MISS) || (nlp_tk && (nlp_tgt != t)));
    fix_c   = is_cond && nlp_tk && FIX_COND_TARGET && (nlp_tgt != t);
    s.ctrl  = is_j || is_cond || is_ind;
    s.fp    = !s.ctrl && nlp_tk;
    s.err   = s.fp || fix_j || fix_c;
    s.tgt   = s.fp ? fall : t;
    return s;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] ds_target_q, ds_target_d;
  logic        upd_valid_q, upd_valid_d;
  logic [31:0] upd_pc_q, upd_pc_d;
  logic [31:0] upd_target_q, upd_target_d;
  logic        upd_taken_q, upd_taken_d;

  logic        acc;
  logic [31:0] pc0, pc1, fall;
  slot_t       s0, s1;
  logic        take0, take1;

  assign acc  = bus.grp_valid && !bus.pause && !bus.flush && !rst;
  assign pc0  = {bus.grp_pc[31:3], 3'b000};
  assign pc1  = {bus.grp_pc[31:3], 3'b100};
  assign fall = pc0 + 32'd8;
  assign s0   = eval_slot(bus.inst0, pc0, fall, bus.nlp_target0, bus.nlp_taken0);
  assign s1   = eval_slot(bus.inst1, pc1, fall, bus.nlp_target1, bus.nlp_taken1);

  // Slot1 is skipped when slot0 errs or is a clean control op (slot1 is then its delay slot)
  assign take0 = !bus.grp_pc[2] && s0.err;
  assign take1 = (bus.grp_pc[2] || (!s0.err && !s0.ctrl)) && s1.err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ds_target_q  <= '0;
      upd_valid_q  <= 1'b0;
      upd_pc_q     <= '0;
      upd_target_q <= '0;
      upd_taken_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ds_target_q  <= ds_target_d;
      upd_valid_q  <= upd_valid_d;
      upd_pc_q     <= upd_pc_d;
      upd_target_q <= upd_target_d;
      upd_taken_q  <= upd_taken_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ds_target_d  = ds_target_q;
    upd_valid_d  = 1'b0;
    upd_pc_d     = '0;
    upd_target_d = '0;
    upd_taken_d  = 1'b0;
    if (bus.flush) begin
      state_d     = StIdle;
      ds_target_d = '0;
    end else if (acc) begin
      unique case (state_q)
        StIdle: begin
          if (take1 && !s1.fp) begin
            state_d     = StWaitDs;
            ds_target_d = s1.tgt;
          end
          if (take0 || take1) begin
            upd_valid_d  = 1'b1;
            upd_pc_d     = take0 ? pc0 : pc1;
            upd_target_d = take0 ? s0.tgt : s1.tgt;
            upd_taken_d  = take0 ? !s0.fp : !s1.fp;
          end
        end
        StWaitDs: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    bus.redirect   = 1'b0;
    bus.redirectPC = '0;
    bus.kill1      = 1'b0;
    if (acc) begin
      if (state_q == StWaitDs) begin
        bus.redirect   = 1'b1;
        bus.redirectPC = ds_target_q;
        bus.kill1      = 1'b1;
      end else if (take0) begin
        bus.redirect   = 1'b1;
        bus.redirectPC = s0.tgt;
      end else if (take1 && s1.fp) begin
        bus.redirect   = 1'b1;
        bus.redirectPC = fall;
      end
    end
  end

  assign bus.wait_ds        = (state_q == StWaitDs);
  assign bus.nlp_upd_valid  = upd_valid_q;
  assign bus.nlp_upd_pc     = upd_pc_q;
  assign bus.nlp_upd_target = upd_target_q;
  assign bus.nlp_upd_taken  = upd_taken_q;

endmodule
